// File: rtl/unidad_control.sv
// unidad_control: hardwired fetch/decode sequencer driving the unidad_procesadora control word
module unidad_control #(
    parameter int             PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [15:0]     mem_data,
    input  logic [3:0]      flags,
    output logic [15:0]     control,
    output logic [3:0]      const_out,
    output logic            in_strobe,
    output logic            out_strobe,
    output logic            halted
);
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, JFETCH, HALT} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [9:0]      ir_q, ir_d;
    logic [3:0]      flag_q, flag_d, const_q, const_d;
    logic            in_q, in_d, out_q, out_d;
    logic [3:0]      op, fop, alu;
    logic [1:0]      rd, ra, rb, sh;
    logic            we, mb, mf, md, taken;
    assign op       = ir_q[9:6];
    assign rd       = ir_q[5:4];
    assign ra       = ir_q[3:2];
    assign rb       = ir_q[1:0];
    assign fop      = mem_data[15:12];
    assign taken    = (op == 4'hD) || flag_q[0];
    assign mem_req  = (state_q == FETCH) || (state_q == JFETCH);
    assign mem_addr = pc_q;
    assign halted   = state_q == HALT;
    assign const_out  = const_q;
    assign in_strobe  = in_q;
    assign out_strobe = out_q;
    // State, PC, latched instruction, flags and registered EXEC-side outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            flag_q  <= '0;
            const_q <= '0;
            in_q    <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flag_q  <= flag_d;
            const_q <= const_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end
    // Sequencing: fetch handshake, two-word jumps, flag capture and halt
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flag_d  = flag_q;
        const_d = '0;
        in_d    = 1'b0;
        out_d   = 1'b0;
        case (state_q)
            IDLE, HALT: state_d = start ? FETCH : state_q;
            FETCH: if (mem_ack) begin
                ir_d    = mem_data[15:6];
                pc_d    = pc_q + PC_W'(1);
                state_d = (fop == 4'hD || fop == 4'hE) ? JFETCH : EXEC;
                const_d = (fop == 4'h1) ? mem_data[3:0] : 4'h0;
                in_d    = fop == 4'hC;
                out_d   = fop == 4'hB;
            end
            JFETCH: if (mem_ack) begin
                pc_d    = taken ? mem_data[PC_W-1:0] : pc_q + PC_W'(1);
                state_d = FETCH;
            end
            EXEC: begin
                state_d = (op == 4'hF) ? HALT : FETCH;
                flag_d  = (op >= 4'h2 && op <= 4'h9) ? flags : flag_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // Opcode decode into the datapath control word, live only in EXEC
    always_comb begin
        we  = 1'b1;
        mb  = 1'b0;
        mf  = 1'b0;
        md  = 1'b0;
        alu = 4'b0000;
        sh  = 2'b00;
        case (op)
            4'h1: mb = 1'b1;
            4'h2: alu = 4'b0010;
            4'h3: alu = 4'b0101;
            4'h4: alu = 4'b1000;
            4'h5: alu = 4'b1010;
            4'h6: alu = 4'b1100;
            4'h7: alu = 4'b1110;
            4'h8: begin mf = 1'b1; sh = 2'b10; end
            4'h9: begin mf = 1'b1; sh = 2'b01; end
            4'hA: alu = 4'b0001;
            4'hC: md = 1'b1;
            default: we = 1'b0;
        endcase
        control = (state_q == EXEC && op != 4'h0 && op != 4'hF) ?
                  {ra, (op == 4'hB) ? rd : rb, rd, we, mb, alu, sh, mf, md} : 16'h0000;
    end
endmodule

// File: tb/tb_unidad_control.sv
// tb_unidad_control: scoreboard bench running a directed program through the sequencer
module tb_unidad_control;
    logic        clk, reset, start, mem_req, mem_ack, in_strobe, out_strobe, halted;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data, control;
    logic [3:0]  flags, const_out;
    logic [15:0] mem [256];
    logic [3:0]  ftab [256];
    typedef struct packed {logic f; logic [21:0] v;} ev_t;
    ev_t q[$];
    int errors = 0, checks = 0, delay = 0, cnt = 0;

    unidad_control dut (
        .clk(clk), .reset(reset), .start(start), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .flags(flags), .control(control),
        .const_out(const_out), .in_strobe(in_strobe), .out_strobe(out_strobe), .halted(halted)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic pf(input logic [7:0] a);
        q.push_back({1'b0, 14'h0, a});
    endtask

    task automatic px(input logic [15:0] c, input logic [3:0] k, input logic i, input logic o);
        q.push_back({1'b1, c, k, i, o});
    endtask

    task automatic push_prog();
        pf(8'h00); pf(8'h01);
        pf(8'h02); px(16'h0700, 4'h6, 0, 0);
        pf(8'h03); px(16'h5A20, 4'h0, 0, 0);
        pf(8'h04); pf(8'h05);
        pf(8'h10); px(16'h0250, 4'h0, 0, 0);
        pf(8'h11); pf(8'h12);
        pf(8'h13); px(16'h0A01, 4'h0, 1, 0);
        pf(8'h14); px(16'h1400, 4'h0, 0, 1);
        pf(8'h15); px(16'h6E80, 4'h0, 0, 0);
        pf(8'h16); pf(8'h17);
        pf(8'hFF);
        pf(8'h00); pf(8'h01);
        pf(8'h30); px(16'h460A, 4'h0, 0, 0);
        pf(8'h31);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
        #1 chk("halt_reached", halted, 1);
        chk("queue_drained", q.size(), 0);
    endtask

    // program memory responder with configurable ack latency
    initial begin
        mem_ack = 0; mem_data = 0; flags = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 0;
                cnt = 0;
            end else if (mem_req && !reset) begin
                if (cnt >= delay) begin
                    mem_ack = 1;
                    mem_data = mem[mem_addr];
                    flags = ftab[mem_addr];
                end else cnt++;
            end else cnt = 0;
        end
    end

    // monitor: fetch handshakes and non-idle EXEC outputs are checked against the queue
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (mem_req) chk("ctl_idle_in_fetch", control, 16'h0000);
                if (mem_req && mem_ack) begin
                    if (q.size() == 0) chk("unexpected_fetch", {1'b0, 14'h0, mem_addr}, 23'h7FFFFF);
                    else begin
                        e = q.pop_front();
                        chk("fetch_addr", {1'b0, 14'h0, mem_addr}, e);
                    end
                end
                if (control != 0 || const_out != 0 || in_strobe || out_strobe) begin
                    if (q.size() == 0) chk("unexpected_exec", {1'b1, control, const_out, in_strobe, out_strobe}, 23'h0);
                    else begin
                        e = q.pop_front();
                        chk("exec_out", {1'b1, control, const_out, in_strobe, out_strobe}, e);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = 16'h0000; ftab[i] = 4'h0; end
        mem[8'h00] = 16'hE000; mem[8'h01] = 16'h0030;
        mem[8'h02] = 16'h1406;
        mem[8'h03] = 16'h2940; ftab[8'h03] = 4'b0001;
        mem[8'h04] = 16'hE000; mem[8'h05] = 16'h0010;
        mem[8'h10] = 16'h3000;
        mem[8'h11] = 16'hE000; mem[8'h12] = 16'h0040;
        mem[8'h13] = 16'hC800;
        mem[8'h14] = 16'hB400;
        mem[8'h15] = 16'h4D80; ftab[8'h15] = 4'b0001;
        mem[8'h16] = 16'hD000; mem[8'h17] = 16'h00FF;
        mem[8'h30] = 16'h8500;
        mem[8'h31] = 16'hF000;
        mem[8'h32] = 16'h9000; ftab[8'h32] = 4'b0001;
        mem[8'h33] = 16'hF000;
        reset = 1; start = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_control", control, 16'h0000);
        chk("rst_outs", {const_out, in_strobe, out_strobe, halted}, 7'h0);
        @(negedge clk) reset = 0;
        repeat (2) @(negedge clk);
        #1 chk("idle_no_req", mem_req, 0);
        push_prog();
        pulse_start();
        wait_halted();
        chk("halt_control", control, 16'h0000);
        chk("halt_pc", mem_addr, 8'h32);
        delay = 3;
        pf(8'h32); px(16'h0206, 4'h0, 0, 0); pf(8'h33);
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req", mem_req, 1);
            chk("stall_addr", mem_addr, 8'h32);
            chk("stall_ack_low", mem_ack, 0);
            @(negedge clk);
        end
        wait_halted();
        pulse_start();
        #2 reset = 1;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_addr", mem_addr, 8'h00);
        chk("midrst_outs", {control, const_out, in_strobe, out_strobe, halted}, 23'h0);
        @(negedge clk) reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 chk("post_rst_idle", {mem_req, halted}, 2'b00);
        end
        push_prog();
        pulse_start();
        wait_halted();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
